// File: rtl/wb_serial_master.sv
// wb_serial_master: parses byte-stream read/write packets and runs single 32-bit
// Wishbone cycles, returning status/data bytes on a transmit byte stream.
// Optional feature macro: WBSM_AUTOINC_EN ('w'/'r' auto-increment commands).
module wb_serial_master #(
  parameter int TIMEOUT = 255,
  parameter int AWIDTH  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              cyc,
  output logic              stb,
  output logic              we,
  output logic [AWIDTH-1:0] adr,
  output logic [3:0]        sel,
  output logic [31:0]       dat_o,
  input  logic [31:0]       dat_i,
  input  logic              ack,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t      state, state_n;
  logic [1:0]  cnt;     // byte index within the current phase
  logic [7:0]  tcnt;    // cycles spent waiting for ack
  logic        err;
  logic [31:0] rdata;
  logic        last_tmo;

  assign sel      = 4'hf;
  assign busy     = (state != S_IDLE);
  assign last_tmo = (tcnt == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and bus/stream handshake outputs
  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    cyc      = 1'b0;
    stb      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          case (rx_data)
            8'h57, 8'h52: state_n = S_ADDR;
`ifdef WBSM_AUTOINC_EN
            8'h77:        state_n = S_DATA;
            8'h72:        state_n = S_BUS;
`endif
            default:      state_n = S_IDLE;
          endcase
        end
      end
      S_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid && cnt == 2'd3) state_n = we ? S_DATA : S_BUS;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && cnt == 2'd3) state_n = S_BUS;
      end
      S_BUS: begin
        cyc = 1'b1;
        stb = 1'b1;
        // ack takes priority over an expiring timeout in the same cycle
        if (ack || last_tmo) state_n = S_RESP;
      end
      S_RESP: begin
        tx_valid = 1'b1;
        if (err)     tx_data = 8'h21;
        else if (we) tx_data = 8'h2E;
        else begin
          case (cnt)
            2'd0:    tx_data = rdata[31:24];
            2'd1:    tx_data = rdata[23:16];
            2'd2:    tx_data = rdata[15:8];
            default: tx_data = rdata[7:0];
          endcase
        end
        if (tx_ready && (err || we || cnt == 2'd3)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: command latch, address/data shifters, counters, read capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we    <= 1'b0;
      adr   <= '0;
      dat_o <= '0;
      cnt   <= '0;
      tcnt  <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          tcnt <= '0;
          err  <= 1'b0;
          if (rx_valid) begin
            case (rx_data)
              8'h57: we <= 1'b1;
              8'h52: we <= 1'b0;
`ifdef WBSM_AUTOINC_EN
              8'h77: begin we <= 1'b1; adr <= adr + AWIDTH'(4); end
              8'h72: begin we <= 1'b0; adr <= adr + AWIDTH'(4); end
`endif
              default: ;
            endcase
          end
        end
        S_ADDR: if (rx_valid) begin
          adr <= {adr[AWIDTH-9:0], rx_data};
          cnt <= cnt + 2'd1;
        end
        S_DATA: if (rx_valid) begin
          dat_o <= {dat_o[23:0], rx_data};
          cnt   <= cnt + 2'd1;
        end
        S_BUS: begin
          if (ack) begin
            if (!we) rdata <= dat_i;
          end else if (last_tmo) err <= 1'b1;
          else tcnt <= tcnt + 8'd1;
        end
        S_RESP: if (tx_ready) cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
